// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multicycle controller FSM for the mccpu_jal datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int ALUOP_W = 4,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         WDSel,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               EXTOp,
    output logic [1:0]         NPCOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXE    = STATE_W'(6),
        S_RWB    = STATE_W'(7),
        S_IEXE   = STATE_W'(8),
        S_IWB    = STATE_W'(9),
        S_BRANCH = STATE_W'(10),
        S_JUMP   = STATE_W'(11),
        S_JAL    = STATE_W'(12),
        S_JR     = STATE_W'(13)
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               funct_ok;
    logic               funct_shift;
    logic [ALUOP_W-1:0] funct_alu;
    logic               imm_ok;
    logic               imm_sext;
    logic [ALUOP_W-1:0] imm_alu;

    logic               pc_write;
    logic               ir_write;
    logic               iord;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         wd_sel;
    logic [1:0]         src_a;
    logic [1:0]         src_b;
    logic               ext_op;
    logic [1:0]         npc_op;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // R-type function decode (jr is handled separately, it is not an ALU op)
    always_comb begin
        funct_ok    = 1'b1;
        funct_shift = 1'b0;
        funct_alu   = ALU_NOP;
        case (Funct)
            F_ADD, F_ADDU: funct_alu = ALU_ADD;
            F_SUB, F_SUBU: funct_alu = ALU_SUB;
            F_AND:         funct_alu = ALU_AND;
            F_OR:          funct_alu = ALU_OR;
            F_NOR:         funct_alu = ALU_NOR;
            F_SLT:         funct_alu = ALU_SLT;
            F_SLTU:        funct_alu = ALU_SLTU;
            F_SLL: begin
                funct_alu   = ALU_SLL;
                funct_shift = 1'b1;
            end
            F_SRL: begin
                funct_alu   = ALU_SRL;
                funct_shift = 1'b1;
            end
            default:       funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        imm_ok   = 1'b1;
        imm_sext = 1'b0;
        imm_alu  = ALU_NOP;
        case (Op)
            OP_ADDI, OP_ADDIU: begin
                imm_alu  = ALU_ADD;
                imm_sext = 1'b1;
            end
            OP_SLTI: begin
                imm_alu  = ALU_SLT;
                imm_sext = 1'b1;
            end
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            OP_LUI:  imm_alu = ALU_LUI;
            default: imm_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = S_FETCH;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        src_a     = 2'd0;
        src_b     = 2'd0;
        ext_op    = 1'b0;
        npc_op    = 2'd0;
        alu_op    = ALU_NOP;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                src_a     = 2'd1;
                src_b     = 2'd1;
                alu_op    = ALU_ADD;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                src_a  = 2'd1;
                src_b  = 2'd3;
                ext_op = 1'b1;
                alu_op = ALU_ADD;
                case (Op)
                    OP_RTYPE: begin
                        if (Funct == F_JR) begin
                            state_nxt = S_JR;
                        end else if (funct_ok) begin
                            state_nxt = S_EXE;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        if (imm_ok) begin
                            state_nxt = S_IEXE;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                src_b  = 2'd2;
                ext_op = 1'b1;
                alu_op = ALU_ADD;
                if (Op == OP_LW) begin
                    state_nxt = S_MEMRD;
                end else if (Op == OP_SW) begin
                    state_nxt = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord      = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                wd_sel    = 2'd1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXE: begin
                src_a     = funct_shift ? 2'd2 : 2'd0;
                alu_op    = funct_alu;
                state_nxt = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
            end
            S_IEXE: begin
                src_b     = 2'd2;
                ext_op    = imm_sext;
                alu_op    = imm_alu;
                state_nxt = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                npc_op   = 2'd1;
                pc_write = Zero;
            end
            S_JUMP: begin
                npc_op   = 2'd2;
                pc_write = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4, so the link value comes straight from PC
                npc_op    = 2'd2;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                reg_dst   = 2'd2;
                wd_sel    = 2'd2;
            end
            S_JR: begin
                npc_op   = 2'd3;
                pc_write = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Everything is held quiet while reset is low so no partial write escapes
    assign PCWrite  = rst & pc_write;
    assign IRWrite  = rst & ir_write;
    assign IorD     = rst & iord;
    assign MemWrite = rst & mem_write;
    assign RegWrite = rst & reg_write;
    assign RegDst   = rst ? reg_dst : 2'd0;
    assign WDSel    = rst ? wd_sel  : 2'd0;
    assign ALUSrcA  = rst ? src_a   : 2'd0;
    assign ALUSrcB  = rst ? src_b   : 2'd0;
    assign EXTOp    = rst & ext_op;
    assign NPCOp    = rst ? npc_op  : 2'd0;
    assign ALUOp    = rst ? alu_op  : ALU_NOP;
    assign Illegal  = rst & illegal;
    assign State    = state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Self-checking bench for mc_ctrl_fsm (per-instruction cycle model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       iord;
        logic       memw;
        logic       regw;
        logic [1:0] regdst;
        logic [1:0] wdsel;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic       ext;
        logic [1:0] npc;
        logic [3:0] aluop;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] Op = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       Zero = 1'b0;
    logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, Illegal;
    logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, NPCOp;
    logic [3:0] ALUOp, State;

    int checks = 0;
    int errors = 0;

    vec_t  exp_q[$];
    string name_q[$];
    vec_t  hist[$];
    vec_t  dut_v;

    mc_ctrl_fsm #(.ALUOP_W(4), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .NPCOp(NPCOp), .ALUOp(ALUOp),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    assign dut_v = {State, PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
                    ALUSrcA, ALUSrcB, EXTOp, NPCOp, ALUOp, Illegal};

    // Compare process: one expected vector per cycle, checked mid-cycle
    always @(negedge clk) begin : cmp
        vec_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            hist.push_back(dut_v);
            checks++;
            if (dut_v !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, dut_v, e);
            end
        end
    end

    // ALU operation an R-type funct requests, -1 when unsupported
    function automatic int r_alu(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: return 1;
            6'h22, 6'h23: return 2;
            6'h24:        return 3;
            6'h25:        return 4;
            6'h2A:        return 5;
            6'h2B:        return 6;
            6'h00:        return 7;
            6'h27:        return 8;
            6'h02:        return 10;
            default:      return -1;
        endcase
    endfunction

    function automatic int i_alu(input logic [5:0] o);
        case (o)
            6'h08, 6'h09: return 1;
            6'h0A:        return 5;
            6'h0C:        return 3;
            6'h0D:        return 4;
            6'h0F:        return 9;
            default:      return -1;
        endcase
    endfunction

    function automatic vec_t blank(input int s);
        vec_t v;
        v    = '0;
        v.st = 4'(s);
        return v;
    endfunction

    task automatic push(input vec_t v, input string n);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, got, want);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    function automatic vec_t fetch_vec();
        vec_t v;
        v = blank(0);
        v.pcw = 1'b1; v.irw = 1'b1; v.srca = 2'd1; v.srcb = 2'd1; v.aluop = 4'd1;
        return v;
    endfunction

    // Expected cycle sequence for one instruction, derived from its class
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input string name);
        vec_t v;
        int   ra, ia;
        bit   is_jr, is_r, is_i, known;
        Op = op; Funct = fn; Zero = z;
        hist.delete();
        ra    = r_alu(fn);
        ia    = i_alu(op);
        is_jr = (op == 6'h00) && (fn == 6'h08);
        is_r  = (op == 6'h00) && (ra >= 0);
        is_i  = (ia >= 0);
        known = is_jr || is_r || is_i || op == 6'h23 || op == 6'h2B ||
                op == 6'h04 || op == 6'h02 || op == 6'h03;

        push(fetch_vec(), {name, "/fetch"});
        v = blank(1);
        v.srca = 2'd1; v.srcb = 2'd3; v.ext = 1'b1; v.aluop = 4'd1; v.ill = !known;
        push(v, {name, "/decode"});

        if (is_jr) begin
            v = blank(13); v.npc = 2'd3; v.pcw = 1'b1; push(v, {name, "/jr"});
        end else if (is_r) begin
            v = blank(6);
            v.srca  = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd0;
            v.aluop = 4'(ra);
            push(v, {name, "/exe"});
            v = blank(7); v.regw = 1'b1; v.regdst = 2'd1; push(v, {name, "/rwb"});
        end else if (is_i) begin
            v = blank(8);
            v.srcb  = 2'd2;
            v.ext   = (op == 6'h08 || op == 6'h09 || op == 6'h0A);
            v.aluop = 4'(ia);
            push(v, {name, "/iexe"});
            v = blank(9); v.regw = 1'b1; push(v, {name, "/iwb"});
        end else if (op == 6'h23 || op == 6'h2B) begin
            v = blank(2); v.srcb = 2'd2; v.ext = 1'b1; v.aluop = 4'd1;
            push(v, {name, "/memadr"});
            if (op == 6'h23) begin
                v = blank(3); v.iord = 1'b1; push(v, {name, "/memrd"});
                v = blank(4); v.regw = 1'b1; v.wdsel = 2'd1; push(v, {name, "/memwb"});
            end else begin
                v = blank(5); v.iord = 1'b1; v.memw = 1'b1; push(v, {name, "/memwr"});
            end
        end else if (op == 6'h04) begin
            v = blank(10); v.aluop = 4'd2; v.npc = 2'd1; v.pcw = z;
            push(v, {name, "/branch"});
        end else if (op == 6'h02) begin
            v = blank(11); v.npc = 2'd2; v.pcw = 1'b1; push(v, {name, "/jump"});
        end else if (op == 6'h03) begin
            v = blank(12); v.npc = 2'd2; v.pcw = 1'b1; v.regw = 1'b1;
            v.regdst = 2'd2; v.wdsel = 2'd2;
            push(v, {name, "/jal"});
        end
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        vec_t v;
        int   n_ill;

        // Reset held low for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("reset_quiet", int'(dut_v), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_instr(6'h00, 6'h21, 1'b0, "addu");
        chk("first_fetch_pcw", int'(hist[0].pcw), 1);
        chk("first_fetch_irw", int'(hist[0].irw), 1);
        chk("first_fetch_alu", int'(hist[0].aluop), 1);
        chk("addu_states", int'({hist[0].st, hist[1].st, hist[2].st, hist[3].st}), 'h0167);
        chk("addu_exe_alu", int'(hist[2].aluop), 1);
        chk("addu_rwb_dst", int'(hist[3].regdst), 1);

        run_instr(6'h00, 6'h00, 1'b0, "sll");
        chk("sll_exe_alu", int'(hist[2].aluop), 7);
        chk("sll_exe_srca", int'(hist[2].srca), 2);

        run_instr(6'h00, 6'h02, 1'b0, "srl");
        run_instr(6'h00, 6'h23, 1'b0, "subu");
        run_instr(6'h00, 6'h27, 1'b0, "nor");
        run_instr(6'h00, 6'h2A, 1'b0, "slt");
        run_instr(6'h00, 6'h2B, 1'b0, "sltu");
        run_instr(6'h00, 6'h24, 1'b0, "and");
        run_instr(6'h00, 6'h25, 1'b0, "or");
        run_instr(6'h00, 6'h08, 1'b0, "jr");

        run_instr(6'h23, 6'h11, 1'b0, "lw");
        chk("lw_len", hist.size(), 5);
        chk("lw_memrd_iord", int'(hist[3].iord), 1);
        chk("lw_memwb_wdsel", int'(hist[4].wdsel), 1);

        run_instr(6'h2B, 6'h11, 1'b0, "sw");
        chk("sw_states", int'({hist[0].st, hist[1].st, hist[2].st, hist[3].st}), 'h0125);
        chk("sw_memw", int'(hist[3].memw), 1);

        run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
        chk("beq_taken_pcw", int'(hist[2].pcw), 1);
        chk("beq_taken_alu", int'(hist[2].aluop), 2);
        run_instr(6'h04, 6'h00, 1'b0, "beq_not");
        chk("beq_not_pcw", int'(hist[2].pcw), 0);

        run_instr(6'h02, 6'h00, 1'b0, "j");
        run_instr(6'h03, 6'h00, 1'b0, "jal");
        chk("jal_state", int'(hist[2].st), 12);
        chk("jal_regdst", int'(hist[2].regdst), 2);

        run_instr(6'h08, 6'h00, 1'b0, "addi");
        run_instr(6'h09, 6'h00, 1'b0, "addiu");
        run_instr(6'h0A, 6'h00, 1'b0, "slti");
        run_instr(6'h0C, 6'h00, 1'b0, "andi");
        run_instr(6'h0D, 6'h00, 1'b0, "ori");
        run_instr(6'h0F, 6'h00, 1'b0, "lui");
        chk("lui_alu", int'(hist[2].aluop), 9);
        chk("lui_ext", int'(hist[2].ext), 0);

        run_instr(6'h3F, 6'h00, 1'b0, "ill_op");
        n_ill = 0;
        foreach (hist[i]) n_ill += int'(hist[i].ill);
        chk("ill_op_pulses", n_ill, 1);
        chk("ill_op_len", hist.size(), 2);
        chk("ill_op_enables", int'({hist[1].pcw, hist[1].irw, hist[1].memw, hist[1].regw}), 0);

        run_instr(6'h00, 6'h3F, 1'b0, "ill_funct");
        chk("ill_funct_flag", int'(hist[1].ill), 1);
        chk("ill_funct_len", hist.size(), 2);

        // Reset dropped mid-lw, while in MEMADR
        Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
        push(fetch_vec(), "midrst/fetch");
        v = blank(1); v.srca = 2'd1; v.srcb = 2'd3; v.ext = 1'b1; v.aluop = 4'd1;
        push(v, "midrst/decode");
        drain();
        @(posedge clk);
        #1;
        chk("midrst_memadr", int'(State), 2);
        rst = 1'b0;
        #1;
        chk("midrst_async", int'(dut_v), 0);
        @(negedge clk);
        chk("midrst_hold", int'(dut_v), 0);
        @(posedge clk);
        #1;
        chk("midrst_after_edge", int'(dut_v), 0);
        rst = 1'b1;

        run_instr(6'h23, 6'h00, 1'b0, "lw_after_rst");
        run_instr(6'h02, 6'h00, 1'b0, "j_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
